// File: rtl/rf_arb_pkg.sv
// Shared constants and grant helpers for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam logic [4:0] RF_ZERO_REG = 5'd0;

    // Round-robin pick over up to 8 requesters: first valid index at or after ptr, wrapping modulo n.
    function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                           input int unsigned n = 32'd8);
        logic [7:0]  gnt;
        logic        found;
        int unsigned idx;
        gnt   = 8'd0;
        found = 1'b0;
        for (int unsigned i = 32'd0; i < 32'd8; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((i < n) && !found && valid[idx[2:0]]) begin
                gnt[idx[2:0]] = 1'b1;
                found         = 1'b1;
            end else begin
                found = found;
            end
        end
        return gnt;
    endfunction

    // True when two or more bits of v are set.
    function automatic logic multi_req(input logic [7:0] v);
        return ((v & (v - 8'd1)) != 8'd0);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant generator with its pointer register.
// RF_WR_ARBITER_FIXED_PRIO_EN pins the pointer at 0 (lowest index wins).
module rr_grant
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 3,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            xfer
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [7:0]    valid8_s;
    logic [7:0]    pick8_s;
    logic          pick_unused_s;

    // Grant vector, its encoded index and the next pointer value.
    always_comb begin
        valid8_s              = 8'd0;
        valid8_s[NREQ-1:0]    = req_valid;
        pick8_s               = rr_pick(valid8_s, 3'(ptr_q), NREQ);
        pick_unused_s         = ^pick8_s;
        grant                 = '0;
        grant_idx             = '0;
        ptr_d                 = ptr_q;
        // Reset and stall both suppress every ready bit combinationally.
        if (rst && !hold) begin
            grant = pick8_s[NREQ-1:0];
        end else begin
            grant = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
            end else begin
                grant_idx = grant_idx;
            end
        end
        xfer = |grant;
`ifdef RF_WR_ARBITER_FIXED_PRIO_EN
        ptr_d = '0;
`else
        if (xfer) begin
            if (grant_idx == PW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
`endif
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the register-file write port among NREQ valid/ready requesters; winning write registered (latency 1).
// Build with RF_WR_ARBITER_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 regwrite,
    output logic [AW-1:0]        adr_wr_reg,
    output logic [DW-1:0]        wr_data,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [CW-1:0]        conflict_cnt
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] grant_idx_s;
    logic          xfer_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_data_s;
    logic [7:0]    valid8_s;

    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] data_q, data_d;
    logic [PW-1:0] gid_q, gid_d;
    logic [CW-1:0] cnt_q, cnt_d;

    rr_grant #(.NREQ(NREQ)) u_rr_grant (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx_s),
        .xfer      (xfer_s)
    );

    // Next-state for the output register and the contention counter.
    always_comb begin
        sel_addr_s         = req_addr[grant_idx_s*AW +: AW];
        sel_data_s         = req_data[grant_idx_s*DW +: DW];
        valid8_s           = 8'd0;
        valid8_s[NREQ-1:0] = req_valid;
        regwrite_d         = 1'b0;
        adr_d              = adr_q;
        data_d             = data_q;
        gid_d              = gid_q;
        cnt_d              = cnt_q;
        // A write to x0 still consumes the slot and updates the presented fields.
        if (xfer_s) begin
            adr_d      = sel_addr_s;
            data_d     = sel_data_s;
            gid_d      = grant_idx_s;
            regwrite_d = (sel_addr_s != AW'(RF_ZERO_REG));
        end else begin
            regwrite_d = 1'b0;
        end
        if (rst && !hold && multi_req(valid8_s) && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output register and counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            adr_q      <= '0;
            data_q     <= '0;
            gid_q      <= '0;
            cnt_q      <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            adr_q      <= adr_d;
            data_q     <= data_d;
            gid_q      <= gid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign regwrite     = regwrite_q;
    assign adr_wr_reg   = adr_q;
    assign wr_data      = data_q;
    assign grant_id     = gid_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register file (`regwrite` / `adr_wr_reg` / `wr_data`) between NREQ writeback requesters, e.g. ALU result, load unit and multi-cycle unit.
- Requesters use a valid/ready handshake. Arbitration is round-robin.
- The winning write is registered and driven to the register file one cycle later.
- Sits between the execute/memory stages and the register file. The register file's read ports are untouched.

Parameters:
- NREQ, 3, number of requesters; legal range 2..8.
- AW, 5, register address width.
- DW, 32, data width.
- CW, 16, width of the contention statistics counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (sampled on the rising edge of clk).
- hold  input  1  pipeline stall; while 1, no request is granted.
- req_valid  input  NREQ  per-requester write request.
- req_ready  output  NREQ  per-requester grant; one-hot or zero.
- req_addr  input  NREQ*AW  packed destination addresses; requester i uses bits [i*AW +: AW].
- req_data  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- regwrite  output  1  write enable to the register file.
- adr_wr_reg  output  AW  write address to the register file.
- wr_data  output  DW  write data to the register file.
- grant_id  output  $clog2(NREQ)  index of the requester whose write is currently presented.
- conflict_cnt  output  CW  saturating count of contention cycles.

Behaviour:
- **Reset** (rst=0 at a rising edge):
  - regwrite=0, adr_wr_reg=0, wr_data=0, grant_id=0, conflict_cnt=0.
  - Round-robin pointer ptr=0.
  - req_ready is forced to 0 combinationally whenever rst=0.
  - Reset asserted mid-transfer drops any write granted in the previous cycle; it is not retried.
- **Grant** (combinational):
  - When rst=1 and hold=0, search req_valid starting at index ptr, ascending and wrapping modulo NREQ.
  - The first valid index g gets req_ready[g]=1. All other ready bits are 0.
  - No valid request, or hold=1: req_ready=0.
- **Transfer:** occurs when req_valid[g] & req_ready[g] at a rising edge.
  - Requesters keep valid, addr and data stable until ready. Dropping valid before ready is legal and withdraws the request.
- **Output register** (latency 1):
  - On a transfer cycle, next cycle adr_wr_reg=req_addr[g], wr_data=req_data[g], grant_id=g.
  - regwrite=1 unless req_addr[g]==0.
- **Writes to x0:**
  - Handshake completes normally and the slot is consumed.
  - adr_wr_reg, wr_data and grant_id still update; regwrite=0.
- **No transfer:** regwrite=0 the next cycle. adr_wr_reg, wr_data and grant_id hold their previous values.
- **Pointer:**
  - After a transfer to g: ptr=(g+1) mod NREQ; g=NREQ-1 wraps to 0.
  - No transfer (idle or hold): ptr unchanged.
- **conflict_cnt:**
  - Increments by 1 on each rising edge where rst=1, hold=0, and two or more req_valid bits are set.
  - Saturates at 2^CW-1 and never wraps.
  - hold=1 cycles are not counted.
- **Throughput:** one write per cycle sustained. Back-to-back grants to different requesters need no bubble.
- **Same-address writes:** two requesters targeting the same register in consecutive grants both reach the register file in grant order; the later write wins. No merging or suppression.

Optional Feature:
- Macro: RF_WR_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. ptr is held at 0 and never updated. conflict_cnt is still maintained.
- Undefined: round-robin as above.

Decomposition:
- Shared package rf_arb_pkg holds:
  - constants RF_AW=5, RF_DW=32 and RF_ZERO_REG=5'd0;
  - function rr_pick(valid, ptr) returning the one-hot grant.
- One natural sub-module, rr_grant: the combinational rotate/priority/unrotate grant logic plus the ptr register.
- rf_wr_arbiter instantiates rr_grant and holds the output register and counter.

Test Plan:
1. **Reset:** rst=0 for 2 cycles with req_valid=3'b111 → req_ready=0, regwrite=0, conflict_cnt=0. Release rst → the first grant goes to requester 0.
2. **Single request:** requester 1 valid, addr=5, data=0x0000_0003 → req_ready=3'b010 the same cycle. Next cycle regwrite=1, adr_wr_reg=5, wr_data=3, grant_id=1.
3. **Round-robin:** all three held valid for 6 cycles with addrs 1, 2, 3 → grant order 0,1,2,0,1,2. conflict_cnt=6. regwrite=1 on each cycle following a grant.
4. **x0 write:** requester 2 addr=0, data=0xDEAD_BEEF → ready=3'b100. Next cycle regwrite=0, wr_data=0xDEADBEEF, ptr becomes 0.
5. **Hold:** hold=1 for 3 cycles with req_valid=3'b011 → req_ready=0, regwrite=0, ptr and conflict_cnt unchanged. After release, the grant goes to the index at the saved ptr.
6. **Saturation / mid-op reset:** build with CW=2 and 5 contention cycles → conflict_cnt=3. Then assert rst in the cycle after a grant → regwrite=0 at the next edge and ptr=0.
